// File: rtl/sprite_layer_renderer.sv
// Renders one indexed-colour sprite over a background pixel stream, with a frame-synchronous
// position update and a highlight palette bank that flashes for a few frames after a hit.
module sprite_layer_renderer #(
    parameter int SPR_W        = 35,
    parameter int SPR_H        = 32,
    parameter int IDX_BITS     = 1,
    parameter int SCALE_SHIFT  = 0,
    parameter int TRANSP_IDX   = 0,
    parameter int FLASH_FRAMES = 4,
    parameter int INIT_X       = 0,
    parameter int INIT_Y       = 168,
    parameter int V_ACTIVE     = 480,
    parameter int ADDR_W       = $clog2(SPR_W * SPR_H)
) (
    input  logic                vga_clk,
    input  logic                reset_n,
    input  logic [9:0]          DrawX,
    input  logic [9:0]          DrawY,
    input  logic                blank,
    input  logic [11:0]         bg_rgb,
    input  logic [9:0]          pos_x,
    input  logic [9:0]          pos_y,
    input  logic                pos_we,
    input  logic                hit,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [IDX_BITS-1:0] rom_q,
    output logic [IDX_BITS:0]   pal_idx,
    input  logic [11:0]         pal_rgb,
    output logic [3:0]          red,
    output logic [3:0]          green,
    output logic [3:0]          blue,
    output logic                flashing
);

    localparam logic [10:0]         L_BOX_W  = 11'(SPR_W << SCALE_SHIFT);
    localparam logic [10:0]         L_BOX_H  = 11'(SPR_H << SCALE_SHIFT);
    localparam logic [ADDR_W-1:0]   L_SPR_W  = ADDR_W'(SPR_W);
    localparam logic [IDX_BITS-1:0] L_TRANSP = IDX_BITS'(TRANSP_IDX);

    logic [9:0]          r_sh_x, r_sh_y, r_pos_x, r_pos_y;
    logic [7:0]          r_flash_cnt;
    logic                r_hit_pend, r_flashing;
    logic [ADDR_W-1:0]   r_rom_addr;
    logic                r_vld_d1, r_vld_d2, r_in_box_d1, r_in_box_d2, r_blank_d1, r_blank_d2;
    logic [11:0]         r_bg_d1, r_bg_d2, r_rgb;

    logic                w_tick, w_in_box, w_transp;
    logic [10:0]         w_dx, w_dy, w_ax, w_ay;
    logic [IDX_BITS:0]   w_pal_idx;

    assign w_tick   = (DrawY == 10'(V_ACTIVE)) && (DrawX == 10'd0);
    assign w_dx     = {1'b0, DrawX} - {1'b0, r_pos_x};
    assign w_dy     = {1'b0, DrawY} - {1'b0, r_pos_y};
    assign w_ax     = w_dx >> SCALE_SHIFT;
    assign w_ay     = w_dy >> SCALE_SHIFT;
    assign w_in_box = (DrawX >= r_pos_x) && (w_dx < L_BOX_W) &&
                      (DrawY >= r_pos_y) && (w_dy < L_BOX_H);

    // Shadow position captures writes; the active copy only moves on the frame tick
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sh_x  <= 10'(INIT_X);
            r_sh_y  <= 10'(INIT_Y);
            r_pos_x <= 10'(INIT_X);
            r_pos_y <= 10'(INIT_Y);
        end else begin
            if (pos_we) begin
                r_sh_x <= pos_x;
                r_sh_y <= pos_y;
            end
            if (w_tick) begin
                r_pos_x <= pos_we ? pos_x : r_sh_x;
                r_pos_y <= pos_we ? pos_y : r_sh_y;
            end
        end
    end

    // Flash counter and pending hit; bank select only changes on the frame tick
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flash_cnt <= 8'd0;
            r_hit_pend  <= 1'b0;
            r_flashing  <= 1'b0;
        end else if (w_tick) begin
            if (r_hit_pend || hit) begin
                r_flash_cnt <= 8'(FLASH_FRAMES);
                r_hit_pend  <= 1'b0;
                r_flashing  <= 1'b1;
            end else if (r_flash_cnt != 8'd0) begin
                r_flash_cnt <= r_flash_cnt - 8'd1;
                r_flashing  <= (r_flash_cnt != 8'd1);
            end
        end else if (hit) begin
            r_hit_pend <= 1'b1;
        end
    end

    // Address/side-band pipeline aligned with the one-cycle ROM latency
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rom_addr  <= {ADDR_W{1'b0}};
            r_vld_d1    <= 1'b0;
            r_vld_d2    <= 1'b0;
            r_in_box_d1 <= 1'b0;
            r_in_box_d2 <= 1'b0;
            r_blank_d1  <= 1'b0;
            r_blank_d2  <= 1'b0;
            r_bg_d1     <= 12'd0;
            r_bg_d2     <= 12'd0;
        end else begin
            if (w_in_box) begin
                r_rom_addr <= ADDR_W'(w_ax) + ADDR_W'(w_ay) * L_SPR_W;
            end
            r_vld_d1    <= 1'b1;
            r_vld_d2    <= r_vld_d1;
            r_in_box_d1 <= w_in_box;
            r_in_box_d2 <= r_in_box_d1;
            r_blank_d1  <= blank;
            r_blank_d2  <= r_blank_d1;
            r_bg_d1     <= bg_rgb;
            r_bg_d2     <= r_bg_d1;
        end
    end

    // Palette index and transparency decode for the pixel whose ROM data is on rom_q
    always_comb begin
        w_pal_idx = {(IDX_BITS + 1){1'b0}};
        w_transp  = 1'b0;
        if (r_vld_d2) begin
            w_pal_idx = {r_flashing, rom_q};
        end else begin
            w_pal_idx = {(IDX_BITS + 1){1'b0}};
        end
        if (!r_in_box_d2 || (rom_q == L_TRANSP)) begin
            w_transp = 1'b1;
        end else begin
            w_transp = 1'b0;
        end
    end

    // Final colour select, blanked outside the visible region
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rgb <= 12'd0;
        end else if (!r_vld_d2 || !r_blank_d2) begin
            r_rgb <= 12'd0;
        end else if (w_transp) begin
            r_rgb <= r_bg_d2;
        end else begin
            r_rgb <= pal_rgb;
        end
    end

    assign rom_addr = r_rom_addr;
    assign pal_idx  = w_pal_idx;
    assign flashing = r_flashing;
    assign red      = r_rgb[11:8];
    assign green    = r_rgb[7:4];
    assign blue     = r_rgb[3:0];

endmodule

// File: tb/tb_sprite_layer_renderer.sv
// Directed bench: two renderer instances (unscaled and 2x scaled) with a behavioural ROM and palette.
module tb_sprite_layer_renderer;

    logic        vga_clk = 1'b0;
    logic        reset_n;
    logic [9:0]  DrawX, DrawY, pos_x, pos_y;
    logic        blank, pos_we, hit;
    logic        pos_we2 = 1'b0;
    logic [11:0] bg_rgb;
    logic [10:0] rom_addr, rom_addr2;
    logic        rom_q = 1'b1;
    logic        rom_q2 = 1'b1;
    logic [1:0]  pal_idx, pal_idx2;
    logic [11:0] pal_rgb, pal_rgb2;
    logic [3:0]  red, green, blue, red2, green2, blue2;
    logic        flashing, flashing2;
    logic        rom_mem [0:2047];
    int          checks = 0;
    int          failures = 0;

    always #5 vga_clk = ~vga_clk;

    function automatic logic [11:0] pal_f(input logic [1:0] idx);
        case (idx)
            2'b00:   return 12'h00F;
            2'b01:   return 12'hF80;
            2'b10:   return 12'h0F0;
            default: return 12'hFFF;
        endcase
    endfunction

    assign pal_rgb  = pal_f(pal_idx);
    assign pal_rgb2 = pal_f(pal_idx2);

    always @(posedge vga_clk) begin
        rom_q  <= rom_mem[rom_addr];
        rom_q2 <= rom_mem[rom_addr2];
    end

    sprite_layer_renderer dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .bg_rgb(bg_rgb), .pos_x(pos_x), .pos_y(pos_y), .pos_we(pos_we), .hit(hit),
        .rom_addr(rom_addr), .rom_q(rom_q), .pal_idx(pal_idx), .pal_rgb(pal_rgb),
        .red(red), .green(green), .blue(blue), .flashing(flashing)
    );

    sprite_layer_renderer #(.SCALE_SHIFT(1), .INIT_X(0), .INIT_Y(0)) dut2 (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .bg_rgb(bg_rgb), .pos_x(pos_x), .pos_y(pos_y), .pos_we(pos_we2), .hit(hit),
        .rom_addr(rom_addr2), .rom_q(rom_q2), .pal_idx(pal_idx2), .pal_rgb(pal_rgb2),
        .red(red2), .green(green2), .blue(blue2), .flashing(flashing2)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic px(input logic [9:0] x, input logic [9:0] y);
        DrawX = x;
        DrawY = y;
        @(posedge vga_clk);
        #1;
    endtask

    task automatic tick(input logic we, input logic h);
        DrawX  = 10'd0;
        DrawY  = 10'd480;
        blank  = 1'b0;
        pos_we = we;
        hit    = h;
        @(posedge vga_clk);
        #1;
        pos_we = 1'b0;
        hit    = 1'b0;
        DrawX  = 10'd1;
        DrawY  = 10'd481;
    endtask

    task automatic render(input bit sel2, input logic [9:0] x, input logic [9:0] y,
                          input logic bl, input logic [11:0] bg, input logic [11:0] exp_rgb,
                          input int exp_addr, input string tag);
        DrawX  = x;
        DrawY  = y;
        blank  = bl;
        bg_rgb = bg;
        @(posedge vga_clk);
        #1;
        if (exp_addr >= 0)
            check_value({tag, "_addr"}, sel2 ? 32'(rom_addr2) : 32'(rom_addr), 32'(exp_addr));
        repeat (2) @(posedge vga_clk);
        #1;
        check_value({tag, "_rgb"}, sel2 ? 32'({red2, green2, blue2}) : 32'({red, green, blue}),
                    32'(exp_rgb));
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) rom_mem[i] = 1'b1;
        rom_mem[5] = 1'b0;
        reset_n = 1'b0;
        DrawX = 10'd1; DrawY = 10'd481; blank = 1'b0; bg_rgb = 12'h000;
        pos_x = 10'd0; pos_y = 10'd0; pos_we = 1'b0; hit = 1'b0;
        #12;
        check_value("rst_rgb", 32'({red, green, blue}), 32'h0);
        check_value("rst_addr", 32'(rom_addr), 32'h0);
        check_value("rst_flash", 32'(flashing), 32'h0);
        check_value("rst_pal_idx", 32'(pal_idx), 32'h0);
        @(negedge vga_clk);
        reset_n = 1'b1;

        // Move sprite to (100,168)
        pos_x = 10'd100; pos_y = 10'd168;
        tick(1'b1, 1'b0);

        render(1'b0, 10'd102, 10'd170, 1'b1, 12'h0A5, 12'hF80, 72, "px_basic");
        render(1'b0, 10'd105, 10'd168, 1'b1, 12'h123, 12'h123, 5, "px_transp");
        render(1'b0, 10'd135, 10'd170, 1'b1, 12'h123, 12'h123, -1, "px_right_out");
        render(1'b0, 10'd134, 10'd170, 1'b1, 12'h123, 12'hF80, 104, "px_right_in");
        render(1'b0, 10'd99, 10'd170, 1'b1, 12'h123, 12'h123, -1, "px_left_out");
        render(1'b0, 10'd102, 10'd170, 1'b0, 12'h123, 12'h000, -1, "px_blank");

        // Scaled instance at (0,0)
        render(1'b1, 10'd3, 10'd5, 1'b1, 12'h0A5, 12'hF80, 71, "sc_addr");
        render(1'b1, 10'd69, 10'd5, 1'b1, 12'h0A5, 12'hF80, 104, "sc_in");
        render(1'b1, 10'd70, 10'd5, 1'b1, 12'h0A5, 12'h0A5, -1, "sc_out");

        // Position write mid-frame must not tear
        pos_x = 10'd200; pos_y = 10'd50; pos_we = 1'b1;
        px(10'd10, 10'd100);
        pos_we = 1'b0;
        render(1'b0, 10'd102, 10'd170, 1'b1, 12'h0A5, 12'hF80, -1, "pos_no_tear");
        tick(1'b0, 1'b0);
        render(1'b0, 10'd102, 10'd170, 1'b1, 12'h0A5, 12'h0A5, -1, "pos_old_gone");
        render(1'b0, 10'd202, 10'd52, 1'b1, 12'h0A5, 12'hF80, 72, "pos_moved");
        pos_x = 10'd100; pos_y = 10'd168;
        tick(1'b1, 1'b0);
        render(1'b0, 10'd102, 10'd170, 1'b1, 12'h0A5, 12'hF80, 72, "pos_we_tick");

        // Flash: hit mid-frame, visible from the next tick for 4 ticks
        hit = 1'b1;
        px(10'd5, 10'd10);
        hit = 1'b0;
        check_value("fl_pre", 32'(flashing), 32'h0);
        tick(1'b0, 1'b0);
        check_value("fl_on", 32'(flashing), 32'h1);
        render(1'b0, 10'd102, 10'd170, 1'b1, 12'h0A5, 12'hFFF, -1, "fl_bank");
        check_value("fl_pal_msb", 32'(pal_idx[1]), 32'h1);
        for (int i = 1; i <= 4; i++) begin
            tick(1'b0, 1'b0);
            check_value("fl_count", 32'(flashing), 32'(i < 4));
        end
        tick(1'b0, 1'b1);
        check_value("fl_hit_on_tick", 32'(flashing), 32'h1);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        hit = 1'b1;
        px(10'd5, 10'd10);
        hit = 1'b0;
        tick(1'b0, 1'b0);
        check_value("fl_restart", 32'(flashing), 32'h1);
        for (int i = 1; i <= 4; i++) begin
            tick(1'b0, 1'b0);
            check_value("fl_restart_cnt", 32'(flashing), 32'(i < 4));
        end

        // Asynchronous reset mid-line while flashing
        tick(1'b0, 1'b1);
        check_value("rs_pre_flash", 32'(flashing), 32'h1);
        render(1'b0, 10'd102, 10'd170, 1'b1, 12'h0A5, 12'hFFF, -1, "rs_pre_px");
        #2;
        reset_n = 1'b0;
        #1;
        check_value("rs_rgb", 32'({red, green, blue}), 32'h0);
        check_value("rs_addr", 32'(rom_addr), 32'h0);
        check_value("rs_flash", 32'(flashing), 32'h0);
        @(negedge vga_clk);
        reset_n = 1'b1;
        tick(1'b0, 1'b0);
        check_value("rs_flash_after", 32'(flashing), 32'h0);
        render(1'b0, 10'd102, 10'd170, 1'b1, 12'h0A5, 12'h0A5, -1, "rs_init_out");
        render(1'b0, 10'd2, 10'd170, 1'b1, 12'h0A5, 12'hF80, 72, "rs_init_in");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
